reg_scan_reader: RTL

REG_SCAN_READER -- requirements
Module: reg_scan_reader

---
 rtl/reg_scan_pkg.sv | 14 +
 rtl/reg_scan_csum.sv | 29 ++
 rtl/reg_scan_reader.sv | 108 ++++++++++
 3 files changed

// File: rtl/reg_scan_pkg.sv
// Shared state encoding and default sizing for the register scan reader.
package reg_scan_pkg;

  localparam int DEFAULT_NUM_REGS = 4;
  localparam int DEFAULT_DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    SEND,
    DONE
  } scan_state_t;

endpackage

// File: rtl/reg_scan_csum.sv
// Modular-sum accumulator for the scan checksum.
// The module only exists when REG_SCAN_CHECKSUM_EN is defined.
`ifdef REG_SCAN_CHECKSUM_EN
module reg_scan_csum
  import reg_scan_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_data,
  output logic [DATA_W-1:0] sum
);

  // Clear wins over add; the sum wraps naturally at DATA_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_data;
    end
  end

endmodule
`endif

// File: rtl/reg_scan_reader.sv
// Walks a register bank through a read mux and streams each word out with a valid/ready handshake.
// Optional checksum accumulator enabled by defining REG_SCAN_CHECKSUM_EN.
module reg_scan_reader
  import reg_scan_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int DATA_W   = DEFAULT_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic [$clog2(NUM_REGS)-1:0] rd_sel,
  input  logic [DATA_W-1:0]           rd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(NUM_REGS)-1:0] out_idx,
  output logic                        busy,
  output logic                        done,
  output logic [DATA_W-1:0]           checksum
);

  localparam int               IDX_W    = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  scan_state_t      state, state_next;
  logic [IDX_W-1:0] idx, idx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // idx only moves when entering SEL, so it doubles as the held read-mux select.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (start) begin
          idx_next   = '0;
          state_next = SEL;
        end
      end
      SEL: begin
        state_next = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (idx == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next   = idx + 1'b1;
            state_next = SEL;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_idx  <= '0;
    end else if (state == SEL) begin
      out_data <= rd_data;
      out_idx  <= idx;
    end
  end

  assign rd_sel    = idx;
  assign out_valid = (state == SEND);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

`ifdef REG_SCAN_CHECKSUM_EN
  logic csum_clear;
  logic csum_add;

  assign csum_clear = (state == IDLE) && start;
  assign csum_add   = (state == SEND) && out_ready;

  reg_scan_csum #(
    .DATA_W (DATA_W)
  ) u_csum (
    .clk      (clk),
    .rst      (rst),
    .clear    (csum_clear),
    .add_en   (csum_add),
    .add_data (out_data),
    .sum      (checksum)
  );
`else
  assign checksum = '0;
`endif

endmodule
